// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM state encodings,
// the RAM data bus type and the default cache geometry.
package inst_fetch_pkg;

   // Default number of index bits: 2^6 = 64 one-word lines
   localparam int INDEX_BITS_DEFAULT = 6;

   // Byte-wide RAM read data
   typedef logic [7:0] RamDataBus;

   // Fetch FSM: IDLE serves hits; BYTE0..BYTE3 issue the four byte reads of
   // a miss; LAST captures the final byte and fills the line.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BYTE0 = 3'd1,
      ST_BYTE1 = 3'd2,
      ST_BYTE2 = 3'd3,
      ST_BYTE3 = 3'd4,
      ST_LAST  = 3'd5
   } fetch_state_e;

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped, one-word-per-line instruction cache. Lookup is purely
// combinational so a hit can be registered on the very next edge; the single
// write port fills a whole line (tag, data, valid) in one cycle.
module icache
   import inst_fetch_pkg::*;
#(
   parameter int INDEX_BITS = INDEX_BITS_DEFAULT,
   parameter int TAG_BITS   = 24
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [INDEX_BITS-1:0] lookup_index,
   input  logic [TAG_BITS-1:0]   lookup_tag,
   output logic                  lookup_hit,
   output logic [31:0]           lookup_data,
   input  logic                  write_en,
   input  logic [INDEX_BITS-1:0] write_index,
   input  logic [TAG_BITS-1:0]   write_tag,
   input  logic [31:0]           write_data
);
   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]    valid_q;
   logic [LINES-1:0]    valid_d;
   logic [TAG_BITS-1:0] tag_q  [LINES];
   logic [31:0]         data_q [LINES];

   // A line becomes valid once written; only reset ever clears it
   for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
      assign valid_d[gi] = valid_q[gi] | (write_en && (write_index == INDEX_BITS'(gi)));
   end

   // Valid bits: synchronous clear on reset, reset wins over a same-cycle fill
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Tag and data arrays: no reset needed, the valid bit qualifies them
   always_ff @(posedge clock) begin
      if (write_en && !reset) begin
         tag_q[write_index]  <= write_tag;
         data_q[write_index] <= write_data;
      end
   end

   // Combinational lookup
   always_comb begin
      lookup_hit  = valid_q[lookup_index] && (tag_q[lookup_index] == lookup_tag);
      lookup_data = data_q[lookup_index];
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch unit: serves 32-bit requests from a direct-mapped cache
// and, on a miss, assembles the word little-endian from four sequential
// byte reads of a single-port RAM whose data returns one cycle after its
// address. All outputs are registered except fetch_busy.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int INDEX_BITS = INDEX_BITS_DEFAULT,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  fetch_ce,
   input  logic [ADDR_WIDTH-1:0] fetch_address,
   input  logic                  fetch_flush,
   output logic                  fetch_valid,
   output logic [31:0]           fetch_instruction,
   output logic                  fetch_busy,
   output logic                  ram_read,
   output logic [ADDR_WIDTH-1:0] ram_address,
   input  logic [7:0]            ram_data
);
   localparam int TAG_BITS  = ADDR_WIDTH - INDEX_BITS - 2;
   localparam int LINE_BITS = ADDR_WIDTH - 2;

   fetch_state_e          state_q, state_d;
   logic [LINE_BITS-1:0]  line_q, line_d;        // word address of the request being served
   logic [23:0]           bytes_q, bytes_d;      // bytes 0..2 of a miss; byte 3 comes straight off the bus
   logic                  valid_q, valid_d;
   logic [31:0]           instr_q, instr_d;
   logic                  ram_read_q, ram_read_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;

   logic                  cache_hit;
   logic [31:0]           cache_data;
   logic                  cache_we;
   logic [31:0]           assembled;
   logic [LINE_BITS-1:0]  req_line;
   RamDataBus             ram_byte;

   // Byte offset within the word is irrelevant for word fetches
   logic unused_addr_bits;
   assign unused_addr_bits = ^fetch_address[1:0];

   assign ram_byte  = ram_data;
   assign req_line  = fetch_address[ADDR_WIDTH-1:2];
   assign assembled = {ram_byte, bytes_q};

   icache #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_icache (
      .clock        (clock),
      .reset        (reset),
      .lookup_index (fetch_address[INDEX_BITS+1:2]),
      .lookup_tag   (fetch_address[ADDR_WIDTH-1:INDEX_BITS+2]),
      .lookup_hit   (cache_hit),
      .lookup_data  (cache_data),
      .write_en     (cache_we),
      .write_index  (line_q[INDEX_BITS-1:0]),
      .write_tag    (line_q[LINE_BITS-1:INDEX_BITS]),
      .write_data   (assembled)
   );

   // Next state, byte assembly, RAM drive and cache fill
   always_comb begin
      state_d    = state_q;
      line_d     = line_q;
      bytes_d    = bytes_q;
      valid_d    = 1'b0;
      instr_d    = instr_q;
      ram_read_d = 1'b0;
      ram_addr_d = ram_addr_q;
      cache_we   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A flush in the request cycle drops the request outright
            if (fetch_ce && !fetch_flush) begin
               line_d = req_line;
               if (cache_hit) begin
                  valid_d = 1'b1;
                  instr_d = cache_data;
               end else begin
                  state_d    = ST_BYTE0;
                  ram_read_d = 1'b1;
                  ram_addr_d = {req_line, 2'd0};
               end
            end
         end
         ST_BYTE0: begin
            if (fetch_flush) begin
               state_d = ST_IDLE;
            end else begin
               state_d    = ST_BYTE1;
               ram_read_d = 1'b1;
               ram_addr_d = {line_q, 2'd1};
            end
         end
         ST_BYTE1: begin
            if (fetch_flush) begin
               state_d = ST_IDLE;
            end else begin
               bytes_d[7:0] = ram_byte;
               state_d      = ST_BYTE2;
               ram_read_d   = 1'b1;
               ram_addr_d   = {line_q, 2'd2};
            end
         end
         ST_BYTE2: begin
            if (fetch_flush) begin
               state_d = ST_IDLE;
            end else begin
               bytes_d[15:8] = ram_byte;
               state_d       = ST_BYTE3;
               ram_read_d    = 1'b1;
               ram_addr_d    = {line_q, 2'd3};
            end
         end
         ST_BYTE3: begin
            if (fetch_flush) begin
               state_d = ST_IDLE;
            end else begin
               bytes_d[23:16] = ram_byte;
               state_d        = ST_LAST;
            end
         end
         ST_LAST: begin
            // The fill is kept even when flushed; only the delivery is cancelled
            cache_we = 1'b1;
            state_d  = ST_IDLE;
            if (!fetch_flush) begin
               valid_d = 1'b1;
               instr_d = assembled;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset overrides everything, including mid-miss
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         line_q     <= '0;
         bytes_q    <= '0;
         valid_q    <= 1'b0;
         instr_q    <= '0;
         ram_read_q <= 1'b0;
         ram_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         line_q     <= line_d;
         bytes_q    <= bytes_d;
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         ram_read_q <= ram_read_d;
         ram_addr_q <= ram_addr_d;
      end
   end

   assign fetch_valid       = valid_q;
   assign fetch_instruction = instr_q;
   assign ram_read          = ram_read_q;
   assign ram_address       = ram_addr_q;
   assign fetch_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_inst_fetch.sv
// Randomised scoreboard bench for inst_fetch with a byte RAM model and a
// line-level cache reference model.
`timescale 1ns/1ps
module tb_inst_fetch;
   localparam int IB = 6;
   localparam int AW = 32;

   logic        clock = 1'b0;
   logic        reset;
   logic        fetch_ce;
   logic [31:0] fetch_address;
   logic        fetch_flush;
   logic        fetch_valid;
   logic [31:0] fetch_instruction;
   logic        fetch_busy;
   logic        ram_read;
   logic [31:0] ram_address;
   logic [7:0]  ram_data;

   always #5 clock = ~clock;

   inst_fetch #(.INDEX_BITS(IB), .ADDR_WIDTH(AW)) dut (
      .clock             (clock),
      .reset             (reset),
      .fetch_ce          (fetch_ce),
      .fetch_address     (fetch_address),
      .fetch_flush       (fetch_flush),
      .fetch_valid       (fetch_valid),
      .fetch_instruction (fetch_instruction),
      .fetch_busy        (fetch_busy),
      .ram_read          (ram_read),
      .ram_address       (ram_address),
      .ram_data          (ram_data)
   );

   // RAM: data returns the cycle after its address
   logic [7:0] mem [4096];
   always @(posedge clock) ram_data <= mem[ram_address[11:0]];

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [31:0] val;
   } exp_t;

   exp_t word_q[$];
   exp_t addr_q[$];
   exp_t mon_e;

   int n_vec  = 0;
   int n_fail = 0;

   // Reference cache: per index, is a word present and which tag
   logic        m_valid [64];
   logic [23:0] m_tag   [64];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      logic [11:0] b;
      b = {addr[11:2], 2'b00};
      return {mem[b + 12'd3], mem[b + 12'd2], mem[b + 12'd1], mem[b]};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
   endtask

   // Monitor: every delivered word and every RAM read must match the head of its queue
   always @(negedge clock) begin
      if (fetch_valid === 1'b1) begin
         if (word_q.size() == 0) begin
            check("unexpected fetch_valid", {31'd0, fetch_valid}, 32'd0);
         end else begin
            mon_e = word_q.pop_front();
            check("valid cycle", cyc, mon_e.cyc);
            check("instruction", fetch_instruction, mon_e.val);
            $display("fetch word cyc=%0d instr=%h", cyc, fetch_instruction);
         end
      end
      if (ram_read === 1'b1) begin
         if (addr_q.size() == 0) begin
            check("unexpected ram_read", {31'd0, ram_read}, 32'd0);
         end else begin
            mon_e = addr_q.pop_front();
            check("ram read cycle", cyc, mon_e.cyc);
            check("ram_address", ram_address, mon_e.val);
         end
      end
   end

   // One request. flush_k / rst_k: 1..4 = BYTE0..BYTE3 cycle, 5 = LAST cycle, 0 = none.
   task automatic do_fetch(input logic [31:0] addr, input int flush_k, input int rst_k, input bit drop);
      int          n;
      int          idx;
      int          stop;
      logic [23:0] tag;
      logic [31:0] base;
      logic        hit;
      bit          done;
      idx  = int'(addr[7:2]);
      tag  = addr[31:8];
      base = {addr[31:2], 2'b00};
      hit  = m_valid[idx] && (m_tag[idx] == tag);
      n    = cyc;
      fetch_address = addr;
      fetch_ce      = 1'b1;
      fetch_flush   = drop;
      if (drop) begin
         step();
         fetch_ce    = 1'b0;
         fetch_flush = 1'b0;
         check("busy after dropped request", {31'd0, fetch_busy}, 32'd0);
         $display("req %h dropped", addr);
      end else if (hit) begin
         word_q.push_back('{n + 1, mem_word(base)});
         step();
         fetch_ce      = 1'b0;
         fetch_address = $urandom;
         check("busy after hit", {31'd0, fetch_busy}, 32'd0);
         $display("req %h hit", addr);
      end else begin
         stop = 6;
         if (flush_k > 0) stop = flush_k;
         if (rst_k > 0) stop = rst_k;
         for (int k = 1; k <= 4; k++)
            if (k <= stop) addr_q.push_back('{n + k, base + 32'(k - 1)});
         if (stop == 6) word_q.push_back('{n + 6, mem_word(base)});
         if (stop == 6 || (stop == 5 && rst_k == 0)) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
         end
         step();
         fetch_ce = 1'b0;
         done     = 1'b0;
         for (int k = 1; k <= 5; k++) begin
            if (!done) begin
               check("busy during miss", {31'd0, fetch_busy}, 32'd1);
               if (k == stop) begin
                  if (flush_k == k) fetch_flush = 1'b1;
                  else reset = 1'b1;
                  done = 1'b1;
               end
               step();
               fetch_flush = 1'b0;
               reset       = 1'b0;
            end
         end
         check("busy after miss", {31'd0, fetch_busy}, 32'd0);
         if (rst_k > 0) begin
            model_clear();
            check("valid after reset", {31'd0, fetch_valid}, 32'd0);
            check("instruction after reset", fetch_instruction, 32'd0);
            check("ram_read after reset", {31'd0, ram_read}, 32'd0);
            check("ram_address after reset", ram_address, 32'd0);
         end
         $display("req %h miss flush=%0d reset=%0d", addr, flush_k, rst_k);
      end
   endtask

   initial begin
      int r;
      reset         = 1'b1;
      fetch_ce      = 1'b0;
      fetch_flush   = 1'b0;
      fetch_address = '0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      mem[0]     = 8'h13; mem[1]     = 8'h00; mem[2]     = 8'h00; mem[3]     = 8'h00;
      mem[12'h100] = 8'hb7; mem[12'h101] = 8'h00; mem[12'h102] = 8'h01; mem[12'h103] = 8'h00;
      model_clear();
      repeat (3) step();
      reset = 1'b0;
      check("reset fetch_valid", {31'd0, fetch_valid}, 32'd0);
      check("reset fetch_instruction", fetch_instruction, 32'd0);
      check("reset ram_read", {31'd0, ram_read}, 32'd0);
      check("reset ram_address", ram_address, 32'd0);
      check("reset fetch_busy", {31'd0, fetch_busy}, 32'd0);

      // Directed scenarios
      do_fetch(32'h0000, 0, 0, 1'b0);    // cold miss -> 0x00000013
      do_fetch(32'h0000, 0, 0, 1'b0);    // hit
      do_fetch(32'h0100, 0, 0, 1'b0);    // conflicting tag -> 0x000100B7
      do_fetch(32'h0000, 0, 0, 1'b0);    // evicted -> miss
      do_fetch(32'h0008, 3, 0, 1'b0);    // flush in BYTE2
      do_fetch(32'h0008, 0, 0, 1'b0);    // full miss again
      do_fetch(32'h000C, 5, 0, 1'b0);    // flush in LAST, line still filled
      do_fetch(32'h000C, 0, 0, 1'b0);    // hit
      do_fetch(32'h0010, 0, 0, 1'b1);    // flush with request in IDLE: dropped
      do_fetch(32'h0000, 0, 0, 1'b0);    // hit, line present
      do_fetch(32'h0004, 0, 2, 1'b0);    // reset in BYTE1
      do_fetch(32'h0000, 0, 0, 1'b0);    // miss: valid bits cleared
      do_fetch(32'h0000, 0, 0, 1'b0);    // back-to-back hits
      do_fetch(32'h0008, 0, 0, 1'b0);
      do_fetch(32'h0000, 0, 0, 1'b0);

      // Randomised traffic
      for (int t = 0; t < 400; t++) begin
         r = int'($urandom_range(0, 39));
         if (r < 4)       do_fetch(32'($urandom_range(0, 1023)), int'($urandom_range(1, 5)), 0, 1'b0);
         else if (r < 6)  do_fetch(32'($urandom_range(0, 1023)), 0, 0, 1'b1);
         else if (r == 6) do_fetch(32'($urandom_range(0, 1023)), 0, int'($urandom_range(1, 5)), 1'b0);
         else             do_fetch(32'($urandom_range(0, 1023)), 0, 0, 1'b0);
         repeat ($urandom_range(0, 2)) begin
            fetch_flush = 1'($urandom_range(0, 1));
            step();
         end
         fetch_flush = 1'b0;
      end

      repeat (10) step();
      check("pending words", 32'(word_q.size()), 32'd0);
      check("pending ram reads", 32'(addr_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
